// File: rtl/z80_pkg.sv
// z80_pkg: shared definitions for the Z80 datapath slice.
//   - alu_op codes shared by the 8-bit and 16-bit ALUs
//   - flag bit positions within F (S Z - H - P/V N C)
//   - register-file byte index order (high byte of each pair on the even index)
//   - flags8(): assembles an 8-bit-ALU flag byte from a result and its H/PV/N/C bits
package z80_pkg;

  localparam logic [3:0] OP_NOP    = 4'd0;
  localparam logic [3:0] OP_INCR_A = 4'd1;
  localparam logic [3:0] OP_DECR_A = 4'd2;
  localparam logic [3:0] OP_ADD    = 4'd3;
  localparam logic [3:0] OP_ADC    = 4'd4;
  localparam logic [3:0] OP_SUB    = 4'd5;
  localparam logic [3:0] OP_SBC    = 4'd6;
  localparam logic [3:0] OP_AND    = 4'd7;
  localparam logic [3:0] OP_OR     = 4'd8;
  localparam logic [3:0] OP_XOR    = 4'd9;
  localparam logic [3:0] OP_CP     = 4'd10;

  localparam int unsigned FLAG_C  = 0;
  localparam int unsigned FLAG_N  = 1;
  localparam int unsigned FLAG_PV = 2;
  localparam int unsigned FLAG_H  = 4;
  localparam int unsigned FLAG_Z  = 6;
  localparam int unsigned FLAG_S  = 7;

  typedef enum logic [3:0] {
    R_B, R_C, R_D, R_E, R_H, R_L, R_IXH, R_IXL, R_IYH, R_IYL, R_SPH, R_SPL
  } reg_sel_e;

  localparam int unsigned NUM_REGS   = 12;
  // B..L are duplicated in the alternate bank; IX, IY and SP are not.
  localparam int unsigned NUM_BANKED = int'(R_IXH);

  function automatic logic [7:0] flags8(input logic [7:0] r, input logic h,
                                        input logic pv, input logic n, input logic c);
    logic [7:0] f;
    f          = '0;
    f[FLAG_S]  = r[7];
    f[FLAG_Z]  = (r == 8'h00);
    f[FLAG_H]  = h;
    f[FLAG_PV] = pv;
    f[FLAG_N]  = n;
    f[FLAG_C]  = c;
    return f;
  endfunction

endpackage

// File: rtl/z80_alu.sv
// z80_alu: combinational 8-bit and 16-bit ALUs sharing one operation code.
//   op        : alu_op code (z80_pkg OP_*)
//   a8, b8    : 8-bit operands (accumulator, TEMP)
//   f_in      : current flags (carry-in and pass-through value)
//   a16, b16  : 16-bit operands (register pair or MAR, {MDR2,MDR1})
//   r8, f8    : 8-bit result and resulting flags
//   r16, f16  : 16-bit result and resulting flags
module z80_alu
  import z80_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [7:0]  a8,
  input  logic [7:0]  b8,
  input  logic [7:0]  f_in,
  input  logic [15:0] a16,
  input  logic [15:0] b16,
  output logic [7:0]  r8,
  output logic [7:0]  f8,
  output logic [15:0] r16,
  output logic [7:0]  f16
);

  logic [8:0]  sum9;
  logic [4:0]  h5;
  logic        cy8;
  logic [16:0] sum17;
  logic [12:0] h13;
  logic        cy16;
  logic        sub16;

  always_comb begin
    r8   = a8;
    f8   = f_in;
    sum9 = '0;
    h5   = '0;
    cy8  = 1'b0;
    case (op)
      OP_INCR_A: begin
        r8 = a8 + 8'd1;
        f8 = flags8(r8, a8[3:0] == 4'hF, a8 == 8'h7F, 1'b0, f_in[FLAG_C]);
      end
      OP_DECR_A: begin
        r8 = a8 - 8'd1;
        f8 = flags8(r8, a8[3:0] == 4'h0, a8 == 8'h80, 1'b1, f_in[FLAG_C]);
      end
      OP_ADD, OP_ADC: begin
        cy8  = (op == OP_ADC) & f_in[FLAG_C];
        sum9 = {1'b0, a8} + {1'b0, b8} + {8'd0, cy8};
        h5   = {1'b0, a8[3:0]} + {1'b0, b8[3:0]} + {4'd0, cy8};
        r8   = sum9[7:0];
        f8   = flags8(r8, h5[4], (a8[7] == b8[7]) && (r8[7] != a8[7]), 1'b0, sum9[8]);
      end
      OP_SUB, OP_SBC, OP_CP: begin
        // CP sets flags from the difference but leaves the result as A.
        cy8  = (op == OP_SBC) & f_in[FLAG_C];
        sum9 = {1'b0, a8} - {1'b0, b8} - {8'd0, cy8};
        h5   = {1'b0, a8[3:0]} - {1'b0, b8[3:0]} - {4'd0, cy8};
        f8   = flags8(sum9[7:0], h5[4], (a8[7] != b8[7]) && (sum9[7] != a8[7]), 1'b1, sum9[8]);
        r8   = (op == OP_CP) ? a8 : sum9[7:0];
      end
      OP_AND: begin
        r8 = a8 & b8;
        f8 = flags8(r8, 1'b1, ~^r8, 1'b0, 1'b0);
      end
      OP_OR: begin
        r8 = a8 | b8;
        f8 = flags8(r8, 1'b0, ~^r8, 1'b0, 1'b0);
      end
      OP_XOR: begin
        r8 = a8 ^ b8;
        f8 = flags8(r8, 1'b0, ~^r8, 1'b0, 1'b0);
      end
      default: ;
    endcase
  end

  always_comb begin
    r16   = a16;
    f16   = f_in;
    sum17 = '0;
    h13   = '0;
    cy16  = 1'b0;
    sub16 = 1'b0;
    case (op)
      OP_INCR_A: r16 = a16 + 16'd1;
      OP_DECR_A: r16 = a16 - 16'd1;
      OP_ADD: begin
        // ADD rr keeps S, Z and P/V.
        sum17         = {1'b0, a16} + {1'b0, b16};
        h13           = {1'b0, a16[11:0]} + {1'b0, b16[11:0]};
        r16           = sum17[15:0];
        f16[FLAG_H]   = h13[12];
        f16[FLAG_N]   = 1'b0;
        f16[FLAG_C]   = sum17[16];
      end
      OP_ADC, OP_SUB, OP_SBC: begin
        sub16 = (op != OP_ADC);
        cy16  = (op != OP_SUB) & f_in[FLAG_C];
        if (sub16) begin
          sum17 = {1'b0, a16} - {1'b0, b16} - {16'd0, cy16};
          h13   = {1'b0, a16[11:0]} - {1'b0, b16[11:0]} - {12'd0, cy16};
        end else begin
          sum17 = {1'b0, a16} + {1'b0, b16} + {16'd0, cy16};
          h13   = {1'b0, a16[11:0]} + {1'b0, b16[11:0]} + {12'd0, cy16};
        end
        r16          = sum17[15:0];
        f16          = '0;
        f16[FLAG_S]  = r16[15];
        f16[FLAG_Z]  = (r16 == 16'h0000);
        f16[FLAG_H]  = h13[12];
        f16[FLAG_PV] = sub16 ? ((a16[15] != b16[15]) && (r16[15] != a16[15]))
                             : ((a16[15] == b16[15]) && (r16[15] != a16[15]));
        f16[FLAG_N]  = sub16;
        f16[FLAG_C]  = sum17[16];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/z80_datapath.sv
// z80_datapath: Z80 register/bus datapath driven by an external control FSM.
//   clk, rst_L        : clock; asynchronous reset, active high
//   data_in           : external data pins, default data-bus source
//   ld_X / drive_X    : register-file byte load / read selects (B..SPL)
//   drive_reg_data    : one selected register byte onto the data bus
//   drive_reg_addr    : one selected register pair into the 16-bit ALU
//   ld_A, ld_F_*      : accumulator load; flag load from ALU8 / ALU16
//   drive_A, drive_F  : A / F onto the data bus
//   alu_op            : shared ALU operation code
//   drive_alu_data    : ALU8 result onto data bus
//   drive_alu_addr    : ALU16 result onto address bus
//   switch_context    : EXX bank toggle; swap_reg: EX AF,AF' toggle
//   MDR1/MDR2/TEMP    : temporary data registers; MAR: memory address register
//   data_out/addr_out : internal data / address bus values
module z80_datapath
  import z80_pkg::*;
(
  input  logic        clk,
  input  logic        rst_L,
  input  logic [7:0]  data_in,
  input  logic        ld_B, ld_C, ld_D, ld_E, ld_H, ld_L,
  input  logic        ld_IXH, ld_IXL, ld_IYH, ld_IYL, ld_SPH, ld_SPL,
  input  logic        drive_reg_data,
  input  logic        drive_reg_addr,
  input  logic        drive_B, drive_C, drive_D, drive_E, drive_H, drive_L,
  input  logic        drive_IXH, drive_IXL, drive_IYH, drive_IYL, drive_SPH, drive_SPL,
  input  logic        ld_A,
  input  logic        ld_F_data,
  input  logic        ld_F_addr,
  input  logic        drive_A,
  input  logic        drive_F,
  input  logic [3:0]  alu_op,
  input  logic        drive_alu_data,
  input  logic        drive_alu_addr,
  input  logic        switch_context,
  input  logic        swap_reg,
  input  logic        ld_MDR1, ld_MDR2, ld_TEMP,
  input  logic        drive_MDR1, drive_MDR2, drive_TEMP,
  input  logic        ld_MARH, ld_MARL, drive_MAR,
  output logic [7:0]  data_out,
  output logic [15:0] addr_out
);

  logic [NUM_REGS-1:0] drv, ldv;
  // Bit positions follow reg_sel_e (B at bit 0).
  assign drv = {drive_SPL, drive_SPH, drive_IYL, drive_IYH, drive_IXL, drive_IXH,
                drive_L, drive_H, drive_E, drive_D, drive_C, drive_B};
  assign ldv = {ld_SPL, ld_SPH, ld_IYL, ld_IYH, ld_IXL, ld_IXH,
                ld_L, ld_H, ld_E, ld_D, ld_C, ld_B};

  logic        reg_bank_q, af_bank_q;
  logic [7:0]  gp_q [2][NUM_BANKED];
  logic [7:0]  xr_q [NUM_REGS-NUM_BANKED];
  logic [7:0]  a_q [2];
  logic [7:0]  f_q [2];
  logic [7:0]  mdr1_q, mdr2_q, temp_q;
  logic [15:0] mar_q;

  logic [7:0]          cur [NUM_REGS];
  logic [7:0]          wr_val [NUM_REGS];
  logic [7:0]          rf_byte;
  logic [NUM_REGS-1:0] pair_mask;
  logic                pair_hit;
  logic [15:0]         pair_val, alu_a16;
  logic [7:0]          r8, f8, f16;
  logic [15:0]         r16;
  logic [7:0]          data_bus;
  logic [15:0]         addr_bus;

  always_comb begin
    for (int unsigned i = 0; i < NUM_BANKED; i++) cur[i] = gp_q[reg_bank_q][i];
    for (int unsigned i = NUM_BANKED; i < NUM_REGS; i++) cur[i] = xr_q[i-NUM_BANKED];
    rf_byte   = '0;
    pair_hit  = 1'b0;
    pair_val  = '0;
    pair_mask = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++)
      if (drv[i]) rf_byte = rf_byte | cur[i];
    for (int unsigned p = 0; p < NUM_REGS/2; p++) begin
      pair_mask         = '0;
      pair_mask[2*p]    = 1'b1;
      pair_mask[2*p+1]  = 1'b1;
      if (drv == pair_mask) begin
        pair_hit = 1'b1;
        pair_val = {cur[2*p], cur[2*p+1]};
      end
    end
  end

  assign alu_a16 = (drive_reg_addr && pair_hit) ? pair_val : mar_q;

  z80_alu u_alu (
    .op   (alu_op),
    .a8   (a_q[af_bank_q]),
    .b8   (temp_q),
    .f_in (f_q[af_bank_q]),
    .a16  (alu_a16),
    .b16  ({mdr2_q, mdr1_q}),
    .r8   (r8),
    .f8   (f8),
    .r16  (r16),
    .f16  (f16)
  );

  always_comb begin
    if (drive_alu_data)                         data_bus = r8;
    else if (drive_A)                           data_bus = a_q[af_bank_q];
    else if (drive_F)                           data_bus = f_q[af_bank_q];
    else if (drive_MDR1)                        data_bus = mdr1_q;
    else if (drive_MDR2)                        data_bus = mdr2_q;
    else if (drive_TEMP)                        data_bus = temp_q;
    else if (drive_reg_data && $onehot(drv))    data_bus = rf_byte;
    else                                        data_bus = data_in;
  end

  always_comb begin
    if (drive_MAR)           addr_bus = mar_q;
    else if (drive_alu_addr) addr_bus = r16;
    else                     addr_bus = '0;
  end

  // A pair loaded as a whole takes the address bus; a lone byte takes the data bus.
  always_comb begin
    for (int unsigned p = 0; p < NUM_REGS/2; p++) begin
      if (ldv[2*p] && ldv[2*p+1]) begin
        wr_val[2*p]   = addr_bus[15:8];
        wr_val[2*p+1] = addr_bus[7:0];
      end else begin
        wr_val[2*p]   = data_bus;
        wr_val[2*p+1] = data_bus;
      end
    end
  end

  always_ff @(posedge clk or posedge rst_L) begin
    if (rst_L) begin
      reg_bank_q <= 1'b0;
      af_bank_q  <= 1'b0;
      for (int unsigned b = 0; b < 2; b++) begin
        for (int unsigned i = 0; i < NUM_BANKED; i++) gp_q[b][i] <= '0;
        a_q[b] <= '0;
        f_q[b] <= '0;
      end
      for (int unsigned i = 0; i < NUM_REGS-NUM_BANKED; i++) xr_q[i] <= '0;
      mdr1_q <= '0;
      mdr2_q <= '0;
      temp_q <= '0;
      mar_q  <= '0;
    end else begin
      // Loads use the pre-toggle bank selects.
      for (int unsigned i = 0; i < NUM_BANKED; i++)
        if (ldv[i]) gp_q[reg_bank_q][i] <= wr_val[i];
      for (int unsigned i = NUM_BANKED; i < NUM_REGS; i++)
        if (ldv[i]) xr_q[i-NUM_BANKED] <= wr_val[i];
      if (ld_MARH && ld_MARL) mar_q <= addr_bus;
      else begin
        if (ld_MARH) mar_q[15:8] <= data_bus;
        if (ld_MARL) mar_q[7:0]  <= data_bus;
      end
      if (ld_MDR1) mdr1_q <= data_bus;
      if (ld_MDR2) mdr2_q <= data_bus;
      if (ld_TEMP) temp_q <= data_bus;
      if (ld_A)    a_q[af_bank_q] <= data_bus;
      if (ld_F_data)      f_q[af_bank_q] <= f8;
      else if (ld_F_addr) f_q[af_bank_q] <= f16;
      if (switch_context) reg_bank_q <= ~reg_bank_q;
      if (swap_reg)       af_bank_q  <= ~af_bank_q;
    end
  end

  assign data_out = data_bus;
  assign addr_out = addr_bus;

endmodule

// File: tb/tb_z80_datapath.sv
// tb_z80_datapath: directed datapath sequences plus randomized register-file
// and ALU8 traffic checked against a behavioural model.
module tb_z80_datapath;

  localparam int RB = 0, RC = 1, RD = 2, RE = 3, RH = 4, RL = 5;

  logic        clk = 1'b0;
  logic        rst_L;
  logic [7:0]  data_in;
  logic [11:0] drv, ld;
  logic        drive_reg_data, drive_reg_addr;
  logic        ld_A, ld_F_data, ld_F_addr, drive_A, drive_F;
  logic [3:0]  alu_op;
  logic        drive_alu_data, drive_alu_addr, switch_context, swap_reg;
  logic        ld_MDR1, ld_MDR2, ld_TEMP, drive_MDR1, drive_MDR2, drive_TEMP;
  logic        ld_MARH, ld_MARL, drive_MAR;
  logic [7:0]  data_out;
  logic [15:0] addr_out;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  z80_datapath dut (
    .clk(clk), .rst_L(rst_L), .data_in(data_in),
    .ld_B(ld[0]), .ld_C(ld[1]), .ld_D(ld[2]), .ld_E(ld[3]), .ld_H(ld[4]), .ld_L(ld[5]),
    .ld_IXH(ld[6]), .ld_IXL(ld[7]), .ld_IYH(ld[8]), .ld_IYL(ld[9]),
    .ld_SPH(ld[10]), .ld_SPL(ld[11]),
    .drive_reg_data(drive_reg_data), .drive_reg_addr(drive_reg_addr),
    .drive_B(drv[0]), .drive_C(drv[1]), .drive_D(drv[2]), .drive_E(drv[3]),
    .drive_H(drv[4]), .drive_L(drv[5]), .drive_IXH(drv[6]), .drive_IXL(drv[7]),
    .drive_IYH(drv[8]), .drive_IYL(drv[9]), .drive_SPH(drv[10]), .drive_SPL(drv[11]),
    .ld_A(ld_A), .ld_F_data(ld_F_data), .ld_F_addr(ld_F_addr),
    .drive_A(drive_A), .drive_F(drive_F), .alu_op(alu_op),
    .drive_alu_data(drive_alu_data), .drive_alu_addr(drive_alu_addr),
    .switch_context(switch_context), .swap_reg(swap_reg),
    .ld_MDR1(ld_MDR1), .ld_MDR2(ld_MDR2), .ld_TEMP(ld_TEMP),
    .drive_MDR1(drive_MDR1), .drive_MDR2(drive_MDR2), .drive_TEMP(drive_TEMP),
    .ld_MARH(ld_MARH), .ld_MARL(ld_MARL), .drive_MAR(drive_MAR),
    .data_out(data_out), .addr_out(addr_out)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  task automatic clear_all();
    data_in = '0; drv = '0; ld = '0;
    drive_reg_data = 0; drive_reg_addr = 0;
    ld_A = 0; ld_F_data = 0; ld_F_addr = 0; drive_A = 0; drive_F = 0;
    alu_op = '0; drive_alu_data = 0; drive_alu_addr = 0;
    switch_context = 0; swap_reg = 0;
    ld_MDR1 = 0; ld_MDR2 = 0; ld_TEMP = 0;
    drive_MDR1 = 0; drive_MDR2 = 0; drive_TEMP = 0;
    ld_MARH = 0; ld_MARL = 0; drive_MAR = 0;
  endtask

  // Apply the current strobes for one clock edge, then return to idle.
  task automatic tick();
    @(posedge clk);
    #1;
    clear_all();
  endtask

  task automatic load_reg(input int idx, input logic [7:0] v);
    data_in = v; ld[idx] = 1'b1;
    tick();
  endtask

  task automatic read_byte(input string tag, input int idx, input logic [7:0] exp);
    data_in = 8'h5A; drive_reg_data = 1'b1; drv[idx] = 1'b1;
    #1 check(tag, {8'h00, data_out}, {8'h00, exp});
    clear_all();
  endtask

  task automatic read_pair(input string tag, input int hi, input logic [15:0] exp);
    drv[hi] = 1'b1; drv[hi+1] = 1'b1;
    drive_reg_addr = 1'b1; drive_alu_addr = 1'b1; alu_op = 4'd0;
    #1 check(tag, addr_out, exp);
    clear_all();
  endtask

  // Pair op in one cycle: pair <= op(pair).
  task automatic pair_op(input int hi, input logic [3:0] op);
    drv[hi] = 1'b1; drv[hi+1] = 1'b1; ld[hi] = 1'b1; ld[hi+1] = 1'b1;
    drive_reg_addr = 1'b1; drive_alu_addr = 1'b1; alu_op = op;
    tick();
  endtask

  task automatic load_mar_pair(input int hi);
    drv[hi] = 1'b1; drv[hi+1] = 1'b1;
    drive_reg_addr = 1'b1; drive_alu_addr = 1'b1; alu_op = 4'd0;
    ld_MARH = 1'b1; ld_MARL = 1'b1;
    tick();
  endtask

  function automatic int sgn8(input int v);
    return (v > 127) ? v - 256 : v;
  endfunction

  // Z80 8-bit ALU reference computed with integer arithmetic.
  function automatic void ref_alu8(input int op, input int a, input int b, input int f,
                                   output int r, output int nf);
    int ci, s, sv, h, v, n, c, d;
    bit upd;
    ci = f & 1; r = a; nf = f; upd = 1;
    h = 0; v = 0; n = 0; c = 0; d = a;
    case (op)
      1: begin d = (a + 1) & 255; r = d; h = (a % 16 == 15); v = (a == 127); c = ci; end
      2: begin d = (a + 255) & 255; r = d; h = (a % 16 == 0); v = (a == 128); n = 1; c = ci; end
      3, 4: begin
        if (op == 3) ci = 0;
        s = a + b + ci; d = s & 255; r = d;
        sv = sgn8(a) + sgn8(b) + ci;
        h = ((a % 16) + (b % 16) + ci) > 15; v = (sv > 127) || (sv < -128); c = (s > 255);
      end
      5, 6, 10: begin
        if (op != 6) ci = 0;
        s = a - b - ci; d = s & 255;
        sv = sgn8(a) - sgn8(b) - ci;
        h = ((a % 16) - (b % 16) - ci) < 0; v = (sv > 127) || (sv < -128);
        n = 1; c = (s < 0);
        r = (op == 10) ? a : d;
      end
      7, 8, 9: begin
        d = (op == 7) ? (a & b) : (op == 8) ? (a | b) : (a ^ b);
        r = d; h = (op == 7); v = ($countones(d) % 2 == 0);
      end
      default: upd = 0;
    endcase
    if (upd)
      nf = ((d > 127) ? 128 : 0) + ((d == 0) ? 64 : 0) + h * 16 + v * 4 + n * 2 + c;
  endfunction

  int m_reg [2][12];
  int bank;
  int mf;

  initial begin
    clear_all();
    rst_L = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_L = 1'b0;
    tick();

    // Reset asserted between edges clears state immediately.
    load_reg(RD, 8'hBB);
    load_reg(RE, 8'h77);
    read_byte("pre_reset_D", RD, 8'hBB);
    #2 rst_L = 1'b1;
    read_byte("reset_D", RD, 8'h00);
    read_pair("reset_DE", RD, 16'h0000);
    #1 check("reset_addr_idle", addr_out, 16'h0000);
    #1 rst_L = 1'b0;
    tick();

    load_reg(RD, 8'hBB);
    load_reg(RE, 8'hAA);
    load_reg(RH, 8'hCC);
    load_reg(RL, 8'hDD);
    read_pair("DE", RD, 16'hBBAA);
    read_pair("HL", RH, 16'hCCDD);

    load_mar_pair(RH);
    drive_MAR = 1'b1;
    #1 check("MAR_HL", addr_out, 16'hCCDD);
    clear_all();
    data_in = 8'hEE; ld_MDR1 = 1'b1; tick();
    drive_MDR1 = 1'b1;
    #1 check("MDR1", {8'h00, data_out}, 16'h00EE);
    clear_all();
    load_mar_pair(RD);
    drive_MAR = 1'b1; drive_alu_addr = 1'b1;
    #1 check("MAR_DE_prio", addr_out, 16'hBBAA);
    clear_all();

    // DE + {MDR2,MDR1} = BBAA + 00EE
    drv[RD] = 1'b1; drv[RE] = 1'b1; drive_reg_addr = 1'b1;
    drive_alu_addr = 1'b1; alu_op = 4'd3;
    #1 check("alu16_add", addr_out, 16'hBC98);
    clear_all();

    pair_op(RH, 4'd1);
    read_pair("HL_inc", RH, 16'hCCDE);
    load_reg(RH, 8'hFF);
    load_reg(RL, 8'hFF);
    pair_op(RH, 4'd1);
    read_pair("HL_wrap", RH, 16'h0000);
    load_reg(RB, 8'h00);
    load_reg(RC, 8'h00);
    pair_op(RB, 4'd2);
    read_pair("BC_wrap", RB, 16'hFFFF);

    data_in = 8'h7F; ld_A = 1'b1; tick();
    data_in = 8'h01; ld_TEMP = 1'b1; tick();
    alu_op = 4'd3; drive_alu_data = 1'b1; ld_A = 1'b1; ld_F_data = 1'b1;
    #1 check("add8_bus", {8'h00, data_out}, 16'h0080);
    tick();
    drive_A = 1'b1; drive_MDR1 = 1'b1;
    #1 check("A_after_add", {8'h00, data_out}, 16'h0080);
    clear_all();
    drive_F = 1'b1; drive_TEMP = 1'b1;
    #1 check("F_after_add", {8'h00, data_out}, 16'h0094);
    clear_all();
    swap_reg = 1'b1; tick();
    drive_A = 1'b1;
    #1 check("A_alt", {8'h00, data_out}, 16'h0000);
    clear_all();
    swap_reg = 1'b1; tick();
    drive_A = 1'b1;
    #1 check("A_main", {8'h00, data_out}, 16'h0080);
    clear_all();

    load_reg(RB, 8'h12);
    switch_context = 1'b1; tick();
    load_reg(RB, 8'h34);
    read_byte("B_alt", RB, 8'h34);
    switch_context = 1'b1; tick();
    read_byte("B_main", RB, 8'h12);

    // Randomized section starts from a clean reset.
    rst_L = 1'b1;
    #2 rst_L = 1'b0;
    tick();
    foreach (m_reg[b, i]) m_reg[b][i] = 0;
    bank = 0;
    mf = 0;

    for (int it = 0; it < 40; it++) begin
      int k, v, r;
      bit tog;
      k = $urandom_range(0, 11);
      v = $urandom_range(0, 255);
      tog = ($urandom_range(0, 3) == 0);
      data_in = 8'(v); ld[k] = 1'b1; switch_context = tog;
      tick();
      m_reg[(k < 6) ? bank : 0][k] = v;
      if (tog) bank = 1 - bank;
      r = $urandom_range(0, 11);
      read_byte("rf_rand", r, 8'(m_reg[(r < 6) ? bank : 0][r]));
    end

    for (int it = 0; it < 40; it++) begin
      int a, b, op, er, ef;
      a  = $urandom_range(0, 255);
      b  = $urandom_range(0, 255);
      op = $urandom_range(0, 15);
      data_in = 8'(a); ld_A = 1'b1; tick();
      data_in = 8'(b); ld_TEMP = 1'b1; tick();
      ref_alu8(op, a, b, mf, er, ef);
      alu_op = 4'(op); drive_alu_data = 1'b1; ld_F_data = 1'b1; ld_F_addr = 1'b1;
      #1 check("alu8_result", {8'h00, data_out}, 16'(er));
      tick();
      drive_F = 1'b1;
      #1 check("alu8_flags", {8'h00, data_out}, 16'(ef));
      clear_all();
      mf = ef;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
